// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   Decode-side register file with a write-back scoreboard. Provides rs1/rs2
//   operands, with a zero-latency bypass from a write-back in the same cycle.
//   It also counts in-flight destination writes for each register and refuses
//   an issue on a RAW hazard or when a destination counter is full.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   rs1_addr/rs2_addr   source register indices
//   rs1_use/rs2_use     instruction actually reads that source
//   rs1_data/rs2_data   operands (combinational, bypassed)
//   issue_valid         decode presents an instruction
//   issue_rd            destination of the issuing instruction
//   issue_wb_en         issuing instruction writes issue_rd
//   issue_stall         issue refused this cycle (combinational)
//   wb_en/wb_addr/wb_data  write-back from the final stage
//   sb_err              sticky: write-back hit a register with zero count
module regfile_scoreboard #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREG  = 32,
    parameter int unsigned CNT_W = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    input  logic            rs1_use,
    input  logic            rs2_use,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rd,
    input  logic            issue_wb_en,
    output logic            issue_stall,
    input  logic            wb_en,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            sb_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [XLEN-1:0]  regs_q  [NREG];
    logic [CNT_W-1:0] cnt_q   [NREG];
    logic [CNT_W-1:0] cnt_d   [NREG];
    logic [CNT_W-1:0] cnt_eff [NREG];
    logic [NREG-1:0]  wb_dec;
    logic [NREG-1:0]  inc;
    logic             sb_err_q;
    logic             sb_err_d;
    logic             wb_wr;
    logic             pend1;
    logic             pend2;
    logic             rd_full;
    logic             issue_acc;

    assign wb_wr = wb_en && (wb_addr != '0);

    // A write-back retiring in this cycle already counts as complete for the
    // hazard check; the guard on a zero count keeps the counter from underflowing.
    always_comb begin
        for (int unsigned r = 0; r < NREG; r++) begin
            wb_dec[r]  = wb_en && (32'(wb_addr) == r) && (r != 0) && (cnt_q[r] != '0);
            cnt_eff[r] = cnt_q[r] - CNT_W'(wb_dec[r]);
        end
    end

    always_comb begin
        pend1       = (rs1_addr != '0) && (cnt_eff[rs1_addr] != '0);
        pend2       = (rs2_addr != '0) && (cnt_eff[rs2_addr] != '0);
        rd_full     = issue_wb_en && (issue_rd != '0) && (cnt_eff[issue_rd] == CNT_MAX);
        issue_stall = issue_valid && ((rs1_use && pend1) || (rs2_use && pend2) || rd_full);
        issue_acc   = issue_valid && !issue_stall;
    end

    always_comb begin
        for (int unsigned r = 0; r < NREG; r++) begin
            inc[r]   = issue_acc && issue_wb_en && (32'(issue_rd) == r) && (r != 0);
            cnt_d[r] = cnt_q[r] + CNT_W'(inc[r]) - CNT_W'(wb_dec[r]);
        end
    end

    assign sb_err_d = sb_err_q || (wb_wr && (cnt_q[wb_addr] == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned r = 0; r < NREG; r++) begin
                regs_q[r] <= '0;
                cnt_q[r]  <= '0;
            end
            sb_err_q <= 1'b0;
        end else begin
            for (int unsigned r = 0; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            if (wb_wr) begin
                regs_q[wb_addr] <= wb_data;
            end
            sb_err_q <= sb_err_d;
        end
    end

    always_comb begin
        rs1_data = regs_q[rs1_addr];
        if (rs1_addr == '0) begin
            rs1_data = '0;
        end else if (wb_wr && (wb_addr == rs1_addr)) begin
            rs1_data = wb_data;
        end
    end

    always_comb begin
        rs2_data = regs_q[rs2_addr];
        if (rs2_addr == '0) begin
            rs2_data = '0;
        end else if (wb_wr && (wb_addr == rs2_addr)) begin
            rs2_data = wb_data;
        end
    end

    assign sb_err = sb_err_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Testbench for regfile_scoreboard. Directed scenarios carry their own
// expected values; the random traffic task takes them from a behavioural model.
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1_addr, rs2_addr, issue_rd, wb_addr;
    logic        rs1_use, rs2_use, issue_valid, issue_wb_en, wb_en;
    logic [31:0] rs1_data, rs2_data, wb_data;
    logic        issue_stall, sb_err;

    always #5 clk = ~clk;

    regfile_scoreboard #(.XLEN(32), .NREG(32), .CNT_W(2)) dut (
        .clk(clk), .rst(rst),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_use(rs1_use), .rs2_use(rs2_use),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .issue_wb_en(issue_wb_en), .issue_stall(issue_stall),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .sb_err(sb_err)
    );

    typedef struct {
        string       tag;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic        stall;
        logic        err;
    } exp_t;

    typedef struct {
        string       tag;
        logic        rs;
        logic        iv;
        logic [4:0]  a1;
        logic        u1;
        logic [4:0]  a2;
        logic        u2;
        logic [4:0]  rd;
        logic        ien;
        logic        wen;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [31:0] e1;
        logic [31:0] e2;
        logic        es;
        logic        ee;
    } stim_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    // Behavioural model used for random traffic
    logic [31:0] m_regs [32];
    int          m_cnt  [32];
    logic        m_err;

    function automatic int m_eff(input logic [4:0] r);
        int d;
        d = (wb_en && wb_addr == r && r != 0 && m_cnt[r] != 0) ? 1 : 0;
        return m_cnt[r] - d;
    endfunction

    function automatic logic m_stall();
        return issue_valid &&
               ((rs1_use && rs1_addr != 0 && m_eff(rs1_addr) != 0) ||
                (rs2_use && rs2_addr != 0 && m_eff(rs2_addr) != 0) ||
                (issue_wb_en && issue_rd != 0 && m_eff(issue_rd) == 3));
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (wb_en && wb_addr == a) return wb_data;
        return m_regs[a];
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] <= 32'h0;
                m_cnt[i]  <= 0;
            end
            m_err <= 1'b0;
        end else begin
            for (int i = 1; i < 32; i++) begin
                m_cnt[i] <= m_cnt[i]
                          + ((issue_valid && !m_stall() && issue_wb_en && issue_rd == i) ? 1 : 0)
                          - ((wb_en && wb_addr == i && m_cnt[i] != 0) ? 1 : 0);
            end
            if (wb_en && wb_addr != 0) begin
                m_regs[wb_addr] <= wb_data;
                if (m_cnt[wb_addr] == 0) m_err <= 1'b1;
            end
        end
    end

    function automatic stim_t R(input string tag, input logic iv,
                                input logic [4:0] a1, input logic u1,
                                input logic [4:0] a2, input logic u2,
                                input logic [4:0] rd, input logic ien,
                                input logic wen, input logic [4:0] wa,
                                input logic [31:0] wd, input logic [31:0] e1,
                                input logic [31:0] e2, input logic es,
                                input logic ee);
        stim_t s;
        s.tag = tag; s.rs = 1'b0; s.iv = iv; s.a1 = a1; s.u1 = u1;
        s.a2 = a2; s.u2 = u2; s.rd = rd; s.ien = ien; s.wen = wen;
        s.wa = wa; s.wd = wd; s.e1 = e1; s.e2 = e2; s.es = es; s.ee = ee;
        return s;
    endfunction

    function automatic stim_t RST();
        stim_t s;
        s = R("rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        s.rs = 1'b1;
        return s;
    endfunction

    task automatic idle();
        issue_valid = 0; rs1_addr = 0; rs1_use = 0; rs2_addr = 0; rs2_use = 0;
        issue_rd = 0; issue_wb_en = 0; wb_en = 0; wb_addr = 0; wb_data = 0;
    endtask

    // One reset cycle with issue and write-back traffic that must be ignored.
    task automatic pulse_rst();
        rst = 1; issue_valid = 1; issue_rd = 9; issue_wb_en = 1;
        wb_en = 1; wb_addr = 9; wb_data = 32'h99;
        @(posedge clk); #1;
        rst = 0;
        idle();
    endtask

    task automatic apply(input stim_t s);
        exp_t e;
        issue_valid = s.iv; rs1_addr = s.a1; rs1_use = s.u1;
        rs2_addr = s.a2; rs2_use = s.u2; issue_rd = s.rd; issue_wb_en = s.ien;
        wb_en = s.wen; wb_addr = s.wa; wb_data = s.wd;
        e.tag = s.tag; e.rs1 = s.e1; e.rs2 = s.e2; e.stall = s.es; e.err = s.ee;
        sbq.push_back(e);
    endtask

    task automatic test_reset();
        stim_t t[$];
        exp_t  e;
        t.push_back(RST());
        t.push_back(R("reset_read", 1, 5, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        t.push_back(R("reset_noissue", 0, 5, 1, 5, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0));
        foreach (t[i]) begin
            if (t[i].rs) pulse_rst();
            else begin
                apply(t[i]);
                @(negedge clk);
                e = sbq.pop_front();
                checks += 4;
                if (rs1_data !== e.rs1) begin errors++; $display("FAIL %s rs1_data got %h exp %h", e.tag, rs1_data, e.rs1); end
                if (rs2_data !== e.rs2) begin errors++; $display("FAIL %s rs2_data got %h exp %h", e.tag, rs2_data, e.rs2); end
                if (issue_stall !== e.stall) begin errors++; $display("FAIL %s issue_stall got %b exp %b", e.tag, issue_stall, e.stall); end
                if (sb_err !== e.err) begin errors++; $display("FAIL %s sb_err got %b exp %b", e.tag, sb_err, e.err); end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_raw();
        stim_t t[$];
        exp_t  e;
        t.push_back(R("raw_issue5",  1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0));
        t.push_back(R("raw_stall",   1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        t.push_back(R("raw_bypass",  1, 5, 1, 0, 0, 0, 0, 1, 5, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0));
        t.push_back(R("raw_cleared", 1, 5, 1, 5, 1, 0, 0, 0, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0));
        t.push_back(R("raw_reissue", 1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0));
        t.push_back(R("raw_novalid", 0, 5, 1, 0, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0, 0, 0));
        t.push_back(R("raw_retire",  0, 0, 0, 0, 0, 0, 0, 1, 5, 32'h11, 0, 0, 0, 0));
        foreach (t[i]) begin
            apply(t[i]);
            @(negedge clk);
            e = sbq.pop_front();
            checks += 4;
            if (rs1_data !== e.rs1) begin errors++; $display("FAIL %s rs1_data got %h exp %h", e.tag, rs1_data, e.rs1); end
            if (rs2_data !== e.rs2) begin errors++; $display("FAIL %s rs2_data got %h exp %h", e.tag, rs2_data, e.rs2); end
            if (issue_stall !== e.stall) begin errors++; $display("FAIL %s issue_stall got %b exp %b", e.tag, issue_stall, e.stall); end
            if (sb_err !== e.err) begin errors++; $display("FAIL %s sb_err got %b exp %b", e.tag, sb_err, e.err); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_saturate();
        stim_t t[$];
        exp_t  e;
        for (int k = 0; k < 3; k++)
            t.push_back(R("sat_issue7", 1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 0));
        t.push_back(R("sat_full",     1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 1, 0));
        t.push_back(R("sat_inc_dec",  1, 0, 0, 0, 0, 7, 1, 1, 7, 32'h70, 0, 0, 0, 0));
        t.push_back(R("sat_still3",   1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 1, 0));
        t.push_back(R("sat_wb1",      1, 7, 1, 0, 0, 0, 0, 1, 7, 32'h71, 32'h71, 0, 1, 0));
        t.push_back(R("sat_wb2",      1, 7, 1, 0, 0, 0, 0, 1, 7, 32'h72, 32'h72, 0, 1, 0));
        t.push_back(R("sat_wb3",      1, 7, 1, 0, 0, 0, 0, 1, 7, 32'h73, 32'h73, 0, 0, 0));
        t.push_back(R("sat_drained",  1, 7, 1, 7, 1, 0, 0, 0, 0, 0, 32'h73, 32'h73, 0, 0));
        foreach (t[i]) begin
            apply(t[i]);
            @(negedge clk);
            e = sbq.pop_front();
            checks += 4;
            if (rs1_data !== e.rs1) begin errors++; $display("FAIL %s rs1_data got %h exp %h", e.tag, rs1_data, e.rs1); end
            if (rs2_data !== e.rs2) begin errors++; $display("FAIL %s rs2_data got %h exp %h", e.tag, rs2_data, e.rs2); end
            if (issue_stall !== e.stall) begin errors++; $display("FAIL %s issue_stall got %b exp %b", e.tag, issue_stall, e.stall); end
            if (sb_err !== e.err) begin errors++; $display("FAIL %s sb_err got %b exp %b", e.tag, sb_err, e.err); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_x0();
        stim_t t[$];
        exp_t  e;
        t.push_back(R("x0_issue", 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        t.push_back(R("x0_read",  1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        t.push_back(R("x0_wb",    1, 0, 1, 0, 0, 0, 0, 1, 0, 32'h1234, 0, 0, 0, 0));
        t.push_back(R("x0_after", 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        foreach (t[i]) begin
            apply(t[i]);
            @(negedge clk);
            e = sbq.pop_front();
            checks += 4;
            if (rs1_data !== e.rs1) begin errors++; $display("FAIL %s rs1_data got %h exp %h", e.tag, rs1_data, e.rs1); end
            if (rs2_data !== e.rs2) begin errors++; $display("FAIL %s rs2_data got %h exp %h", e.tag, rs2_data, e.rs2); end
            if (issue_stall !== e.stall) begin errors++; $display("FAIL %s issue_stall got %b exp %b", e.tag, issue_stall, e.stall); end
            if (sb_err !== e.err) begin errors++; $display("FAIL %s sb_err got %b exp %b", e.tag, sb_err, e.err); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random();
        exp_t e;
        for (int n = 0; n < 200; n++) begin
            issue_valid = 1'($urandom_range(0, 1));
            rs1_addr    = 5'($urandom_range(0, 7));
            rs1_use     = 1'($urandom_range(0, 1));
            rs2_addr    = 5'($urandom_range(0, 7));
            rs2_use     = 1'($urandom_range(0, 1));
            issue_rd    = 5'($urandom_range(0, 7));
            issue_wb_en = 1'($urandom_range(0, 1));
            wb_en       = 1'($urandom_range(0, 1));
            wb_addr     = 5'($urandom_range(0, 7));
            wb_data     = $urandom;
            e.tag = "random"; e.rs1 = m_read(rs1_addr); e.rs2 = m_read(rs2_addr);
            e.stall = m_stall(); e.err = m_err;
            sbq.push_back(e);
            @(negedge clk);
            e = sbq.pop_front();
            checks += 4;
            if (rs1_data !== e.rs1) begin errors++; $display("FAIL %s rs1_data got %h exp %h", e.tag, rs1_data, e.rs1); end
            if (rs2_data !== e.rs2) begin errors++; $display("FAIL %s rs2_data got %h exp %h", e.tag, rs2_data, e.rs2); end
            if (issue_stall !== e.stall) begin errors++; $display("FAIL %s issue_stall got %b exp %b", e.tag, issue_stall, e.stall); end
            if (sb_err !== e.err) begin errors++; $display("FAIL %s sb_err got %b exp %b", e.tag, sb_err, e.err); end
            @(posedge clk); #1;
        end
        idle();
    endtask

    task automatic test_sberr();
        stim_t t[$];
        exp_t  e;
        t.push_back(RST());
        t.push_back(R("err_wb9",     0, 9, 1, 0, 0, 0, 0, 1, 9, 32'h55, 32'h55, 0, 0, 0));
        t.push_back(R("err_set",     0, 9, 1, 0, 0, 0, 0, 0, 0, 0, 32'h55, 0, 0, 1));
        t.push_back(R("err_issue2",  1, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0, 1));
        t.push_back(R("err_goodwb",  1, 0, 0, 0, 0, 0, 0, 1, 2, 32'hAA, 0, 0, 0, 1));
        t.push_back(R("err_hold",    0, 2, 1, 9, 1, 0, 0, 0, 0, 0, 32'hAA, 32'h55, 0, 1));
        t.push_back(RST());
        t.push_back(R("err_cleared", 1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        foreach (t[i]) begin
            if (t[i].rs) pulse_rst();
            else begin
                apply(t[i]);
                @(negedge clk);
                e = sbq.pop_front();
                checks += 4;
                if (rs1_data !== e.rs1) begin errors++; $display("FAIL %s rs1_data got %h exp %h", e.tag, rs1_data, e.rs1); end
                if (rs2_data !== e.rs2) begin errors++; $display("FAIL %s rs2_data got %h exp %h", e.tag, rs2_data, e.rs2); end
                if (issue_stall !== e.stall) begin errors++; $display("FAIL %s issue_stall got %b exp %b", e.tag, issue_stall, e.stall); end
                if (sb_err !== e.err) begin errors++; $display("FAIL %s sb_err got %b exp %b", e.tag, sb_err, e.err); end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_reset_mid();
        stim_t t[$];
        exp_t  e;
        t.push_back(R("mid_issue3",   1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0));
        t.push_back(R("mid_pending",  1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        t.push_back(RST());
        t.push_back(R("mid_nostall",  1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        t.push_back(R("mid_latewb",   0, 0, 0, 0, 0, 0, 0, 1, 3, 32'h33, 0, 0, 0, 0));
        t.push_back(R("mid_err",      0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 32'h33, 0, 0, 1));
        foreach (t[i]) begin
            if (t[i].rs) pulse_rst();
            else begin
                apply(t[i]);
                @(negedge clk);
                e = sbq.pop_front();
                checks += 4;
                if (rs1_data !== e.rs1) begin errors++; $display("FAIL %s rs1_data got %h exp %h", e.tag, rs1_data, e.rs1); end
                if (rs2_data !== e.rs2) begin errors++; $display("FAIL %s rs2_data got %h exp %h", e.tag, rs2_data, e.rs2); end
                if (issue_stall !== e.stall) begin errors++; $display("FAIL %s issue_stall got %b exp %b", e.tag, issue_stall, e.stall); end
                if (sb_err !== e.err) begin errors++; $display("FAIL %s sb_err got %b exp %b", e.tag, sb_err, e.err); end
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1;
        idle();
        @(posedge clk); #1;
        test_reset();
        test_raw();
        test_saturate();
        test_x0();
        test_random();
        test_sberr();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
Decode-side register file paired with a write-back scoreboard. It is the consumer end of the destination/write-enable path that the decode/execute pipeline register carries forward.
- Supplies rs1/rs2 operands to decode, with same-cycle write-back bypass.
- Accepts write-back (wb_en/wb_addr/wb_data) from the final stage.
- Tracks in-flight destination writes per register and raises issue_stall on RAW hazards or counter saturation.
- Sits between decode and the decode/execute pipeline register.

Parameters:
- XLEN, 32, data width of each register.
- NREG, 32, number of architectural registers; address width is 5 bits.
- CNT_W, 2, width of the per-register in-flight counter; maximum count is 3.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- rs1_addr  in  5  source 1 register index
- rs2_addr  in  5  source 2 register index
- rs1_use  in  1  instruction reads rs1
- rs2_use  in  1  instruction reads rs2
- rs1_data  out  XLEN  source 1 operand (combinational)
- rs2_data  out  XLEN  source 2 operand (combinational)
- issue_valid  in  1  decode presents an instruction for issue
- issue_rd  in  5  destination of the issuing instruction
- issue_wb_en  in  1  issuing instruction writes issue_rd
- issue_stall  out  1  issue refused this cycle (combinational)
- wb_en  in  1  write-back valid
- wb_addr  in  5  write-back destination
- wb_data  in  XLEN  write-back value
- sb_err  out  1  sticky: write-back arrived for a register with zero count

Behaviour:
- Reset (synchronous, rst high at the clock edge):
  - all registers clear to 0;
  - all counters clear to 0;
  - sb_err clears to 0;
  - issue and write-back inputs are ignored that cycle.
  - After reset: rs1_data = rs2_data = 0 and issue_stall = 0.
- Register x0:
  - reads always return 0;
  - writes are discarded;
  - its counter never changes;
  - it never causes a stall.
- Reads:
  - rsN_data = wb_data if wb_en && wb_addr == rsN_addr && rsN_addr != 0;
  - otherwise rsN_data = regs[rsN_addr].
  - This is a same-cycle bypass with zero latency. The stored value is updated at the next edge.
- Write-back decrement:
  - wb_dec(r) = wb_en && wb_addr == r && r != 0 && cnt[r] != 0.
  - cnt_eff(r) = cnt[r] - wb_dec(r).
- Pending and stall:
  - pending(r) = r != 0 && cnt_eff(r) != 0.
  - issue_stall = issue_valid && ((rs1_use && pending(rs1_addr)) || (rs2_use && pending(rs2_addr)) || (issue_wb_en && issue_rd != 0 && cnt_eff(issue_rd) == 3)).
  - issue_stall is 0 whenever issue_valid = 0.
- Issue accept:
  - issue_acc = issue_valid && !issue_stall.
  - If issue_acc && issue_wb_en && issue_rd != 0, then cnt[issue_rd] is incremented at the edge.
- Counter update per register r:
  - cnt[r] <= cnt[r] + inc(r) - wb_dec(r).
  - A simultaneous increment and decrement on the same r leaves cnt[r] unchanged.
  - The counter never wraps: saturation is prevented by the stall, and underflow by the wb_dec guard.
- Write-back with cnt[wb_addr] == 0 and wb_addr != 0:
  - data is still written;
  - the counter stays 0;
  - sb_err is set to 1 and held until rst.
- Write-back to x0 never sets sb_err.
- Multiple in-flight writes to the same rd are permitted, up to 3. The register stays pending until the last write-back.
- Reset mid-operation discards all outstanding counts. Write-backs arriving after reset for pre-reset issues set sb_err.

Test Plan:
- Reset, then read rs1 = 5, rs2 = 0 -> rs1_data = 0, rs2_data = 0, issue_stall = 0, sb_err = 0.
- Issue rd = 5 with wb_en; next cycle issue with rs1 = 5, rs1_use = 1 -> issue_stall = 1. Then wb_en = 1, wb_addr = 5, wb_data = 0xDEADBEEF in the same cycle -> rs1_data = 0xDEADBEEF and issue_stall = 0 in that cycle; cnt[5] = 0 afterwards.
- Issue rd = 7 three times, then a fourth time -> the fourth stalls. Then present wb to 7 together with that fourth issue -> accepted, count stays 3. Three write-backs follow -> rs1 = 7 unstalls only after the third.
- Issue rd = 0 with issue_wb_en = 1, then read x0 with rs1_use -> no stall. Write-back of x0 with 0x1234 -> rs1_data = 0, sb_err = 0.
- With cnt[9] = 0, apply wb_en to 9 with 0x55 -> regs[9] = 0x55 and sb_err = 1. sb_err holds through later traffic and clears only on rst.
- Issue rd = 3 (count 1), assert rst for one cycle -> no stall on rs1 = 3 after reset; a later wb to 3 sets sb_err.
